// File: rtl/johnson_ring_decoder_pkg.sv
// rtl/johnson_ring_decoder_pkg.sv - shared types and constants for the ring/Johnson decoder
package johnson_ring_decoder_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQ      = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

endpackage

// File: rtl/johnson_ring_decoder_classify.sv
// rtl/johnson_ring_decoder_classify.sv - combinational legality check and index decode of a counter state
module johnson_ring_decoder_classify
    import johnson_ring_decoder_pkg::*;
#(
    parameter int N     = 6,
    parameter int IDX_W = $clog2(2*N)
) (
    input  logic             mode,
    input  logic [N-1:0]     code_in,
    output logic             legal,
    output logic             idle,
    output logic [IDX_W-1:0] index
);

    int               pop;
    int               trans;
    logic [IDX_W-1:0] ring_pos;

    always_comb begin
        pop      = 0;
        trans    = 0;
        ring_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (code_in[i]) begin
                pop++;
                ring_pos = IDX_W'(i);
            end
        end
        // A Johnson code has at most one boundary between its run of ones and run of zeros
        for (int i = 0; i < N - 1; i++) begin
            if (code_in[i] != code_in[i+1]) trans++;
        end

        legal = 1'b0;
        idle  = 1'b0;
        index = '0;
        if (mode == MODE_JOHNSON) begin
            legal = (trans <= 1);
            index = code_in[N-1] ? IDX_W'(2*N - pop) : IDX_W'(pop);
        end else begin
            legal = (pop == 1);
            idle  = (pop == 0);
            index = ring_pos;
        end
    end

endmodule

// File: rtl/johnson_ring_decoder.sv
// rtl/johnson_ring_decoder.sv - ring/Johnson counter monitor: index decode, successor check, lock FSM, error count
module johnson_ring_decoder
    import johnson_ring_decoder_pkg::*;
#(
    parameter int N        = 6,
    parameter int IDX_W    = $clog2(2*N),
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             mode,
    input  logic [N-1:0]     code_in,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [IDX_W-1:0] index,
    output logic             illegal,
    output logic             idle,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int STREAK_W = $clog2(LOCK_CNT + 1);

    lock_state_t         state, state_nxt, eff_state;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                prev_mode;
    logic                c_legal, c_idle;
    logic [IDX_W-1:0]    c_index;
    logic [IDX_W-1:0]    last_idx, succ_idx;
    logic                in_seq, seq_err_nxt, illegal_nxt;

    johnson_ring_decoder_classify #(.N(N), .IDX_W(IDX_W)) u_classify (
        .mode    (mode),
        .code_in (code_in),
        .legal   (c_legal),
        .idle    (c_idle),
        .index   (c_index)
    );

    // index only ever holds the last legal sample, so it doubles as the predecessor
    assign last_idx    = (mode == MODE_JOHNSON) ? IDX_W'(2*N - 1) : IDX_W'(N - 1);
    assign succ_idx    = (index == last_idx) ? '0 : index + 1'b1;
    assign in_seq      = (c_index == succ_idx);
    assign illegal_nxt = valid_in && !c_legal && !c_idle;

    always_comb begin
        eff_state   = (mode != prev_mode) ? UNLOCKED : state;
        state_nxt   = state;
        streak_nxt  = streak;
        seq_err_nxt = 1'b0;
        if (valid_in) begin
            if (!c_legal) begin
                state_nxt  = UNLOCKED;
                streak_nxt = '0;
            end else begin
                case (eff_state)
                    UNLOCKED: begin
                        streak_nxt = STREAK_W'(1);
                        state_nxt  = (LOCK_CNT == 1) ? LOCKED : ACQ;
                    end
                    ACQ: begin
                        state_nxt = ACQ;
                        if (in_seq) begin
                            streak_nxt = streak + 1'b1;
                            if (int'(streak) + 1 >= LOCK_CNT) state_nxt = LOCKED;
                        end else begin
                            streak_nxt  = STREAK_W'(1);
                            seq_err_nxt = 1'b1;
                        end
                    end
                    LOCKED: begin
                        state_nxt = LOCKED;
                        if (!in_seq) begin
                            state_nxt   = UNLOCKED;
                            streak_nxt  = '0;
                            seq_err_nxt = 1'b1;
                        end
                    end
                    default: begin
                        state_nxt  = UNLOCKED;
                        streak_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UNLOCKED;
            streak    <= '0;
            prev_mode <= MODE_RING;
            out_valid <= 1'b0;
            index     <= '0;
            illegal   <= 1'b0;
            idle      <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            out_valid <= valid_in;
            illegal   <= illegal_nxt;
            idle      <= valid_in && c_idle;
            seq_err   <= seq_err_nxt;
            locked    <= (state_nxt == LOCKED);
            if (valid_in) prev_mode <= mode;
            if (valid_in && c_legal) index <= c_index;
            if (clr_err) begin
                err_cnt <= '0;
            end else if ((illegal_nxt || seq_err_nxt) && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
